// File: rtl/mem_arbiter.sv
// mem_arbiter: merges an instruction and a data SRAM-like port onto one memory port,
// routing in-order responses back through a source-tag FIFO.
module mem_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [2:0]  data_size,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_size,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] tag_q, tag_d;
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full, sel_data, sel_vld, push, pop, head;

   always_comb begin
      sel_data = (state_q == HOLD_D) || (state_q == IDLE && data_req);
      sel_vld  = (state_q != IDLE) || data_req || inst_req;
      full     = cnt_q == CW'(DEPTH);
      // a full FIFO blocks new requests even when a response frees a slot this cycle
      push     = sel_vld && !full && !reset && mem_addr_ok;
      pop      = mem_data_ok && cnt_q != '0 && !reset;
      head     = tag_q[rptr_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
      tag_q <= tag_d;
   end

   always_comb begin
      state_d = state_q;
      if (!full)
         state_d = (sel_vld && !mem_addr_ok) ? (sel_data ? HOLD_D : HOLD_I) : IDLE;
   end

   always_comb begin
      tag_d = tag_q;
      if (push)
         tag_d[wptr_q] = sel_data;
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      mem_req      = sel_vld && !full && !reset;
      mem_wr       = sel_data ? data_wr : 1'b0;
      mem_wstrb    = sel_data ? data_wstrb : 4'h0;
      mem_addr     = sel_data ? data_addr : inst_addr;
      mem_size     = sel_data ? data_size : 3'd2;
      mem_wdata    = sel_data ? data_wdata : 32'h0;
      data_addr_ok = push && sel_data;
      inst_addr_ok = push && !sel_data;
      data_data_ok = pop && head;
      inst_data_ok = pop && !head;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus constrained-random traffic checked
// against an in-order outstanding-tag queue model.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [2:0]  data_size;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_size;

   int pass_cnt = 0;
   int total = 0;

   bit q[$];
   bit lk_v, lk_d;
   logic        e_req, e_sd, e_daok, e_iaok, e_ddok, e_idok, e_wr;
   logic [3:0]  e_wstrb;
   logic [2:0]  e_size;
   logic [31:0] e_addr, e_wdata;

   mem_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Expected outputs from the current inputs and the outstanding-tag queue.
   task model_eval;
      bit full, sv, pop;
      full = q.size() == 4;
      e_sd = lk_v ? lk_d : data_req;
      sv = lk_v || data_req || inst_req;
      e_req = !reset && sv && !full;
      e_daok = e_req && e_sd && mem_addr_ok;
      e_iaok = e_req && !e_sd && mem_addr_ok;
      pop = !reset && mem_data_ok && q.size() > 0;
      e_ddok = 1'b0;
      e_idok = 1'b0;
      if (pop) begin
         e_ddok = q[0];
         e_idok = !q[0];
      end
      e_addr = e_sd ? data_addr : inst_addr;
      e_wr = e_sd ? data_wr : 1'b0;
      e_wstrb = e_sd ? data_wstrb : 4'h0;
      e_size = e_sd ? data_size : 3'd2;
      e_wdata = e_sd ? data_wdata : 32'h0;
   endtask

   task model_update;
      bit was_full;
      model_eval();
      was_full = q.size() == 4;
      if (reset) begin
         q.delete();
         lk_v = 1'b0;
      end else begin
         if (e_ddok || e_idok) void'(q.pop_front());
         if (e_daok || e_iaok) q.push_back(e_sd);
         if (!was_full) begin
            lk_v = e_req && !mem_addr_ok;
            lk_d = e_sd;
         end
      end
   endtask

   task tick;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task idle_inputs;
      inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
      data_addr = 0; data_size = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task test_reset;
      reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      #2;
      total++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
         $display("FAIL reset_outputs got %b exp 00000",
                  {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
      else pass_cnt++;
      tick();
      idle_inputs();
      reset = 0;
      tick();
   endtask

   task test_priority;
      logic [31:0] ia, da, dw;
      ia = $urandom; da = $urandom; dw = $urandom;
      inst_req = 1; inst_addr = ia; data_req = 1; data_wr = 1; data_addr = da;
      data_wstrb = 4'hf; data_size = 3'd2; data_wdata = dw; mem_addr_ok = 1;
      #2;
      total++;
      if ({data_addr_ok, inst_addr_ok, mem_wr, mem_addr, mem_wdata} !== {3'b101, da, dw})
         $display("FAIL prio_data_first got %b%b %h exp 10 %h", data_addr_ok, inst_addr_ok, mem_addr, da);
      else pass_cnt++;
      tick();
      data_req = 0;
      #2;
      total++;
      if ({data_addr_ok, inst_addr_ok, mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata} !==
          {2'b01, 1'b0, 4'h0, 3'd2, ia, 32'h0})
         $display("FAIL prio_inst_next got %b%b wr=%b st=%h sz=%0d %h exp 01 0 0 2 %h",
                  data_addr_ok, inst_addr_ok, mem_wr, mem_wstrb, mem_size, mem_addr, ia);
      else pass_cnt++;
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = $urandom;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, mem_rdata})
         $display("FAIL prio_resp_data got %b%b %h exp 10 %h", data_data_ok, inst_data_ok, data_rdata, mem_rdata);
      else pass_cnt++;
      tick();
      mem_rdata = $urandom;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok, inst_rdata} !== {2'b01, mem_rdata})
         $display("FAIL prio_resp_inst got %b%b %h exp 01 %h", data_data_ok, inst_data_ok, inst_rdata, mem_rdata);
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   task test_hold;
      logic [31:0] ia, da;
      ia = $urandom; da = $urandom;
      inst_req = 1; inst_addr = ia; mem_addr_ok = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin data_req = 1; data_addr = da; end
         #2;
         total++;
         if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b100, ia})
            $display("FAIL hold_cycle%0d got req=%b ok=%b%b %h exp 1 00 %h",
                     c, mem_req, inst_addr_ok, data_addr_ok, mem_addr, ia);
         else pass_cnt++;
         tick();
      end
      mem_addr_ok = 1;
      #2;
      total++;
      if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, ia})
         $display("FAIL hold_accept got %b%b %h exp 10 %h", inst_addr_ok, data_addr_ok, mem_addr, ia);
      else pass_cnt++;
      tick();
      inst_req = 0;
      #2;
      total++;
      if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b01, da})
         $display("FAIL hold_data_after got %b%b %h exp 01 %h", inst_addr_ok, data_addr_ok, mem_addr, da);
      else pass_cnt++;
      tick();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      #2;
      total++;
      if ({inst_data_ok, data_data_ok} !== 2'b10)
         $display("FAIL hold_resp0 got %b%b exp 10", inst_data_ok, data_data_ok);
      else pass_cnt++;
      tick();
      #2;
      total++;
      if ({inst_data_ok, data_data_ok} !== 2'b01)
         $display("FAIL hold_resp1 got %b%b exp 01", inst_data_ok, data_data_ok);
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   task test_full;
      data_req = 1; data_wr = 0; mem_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         data_addr = $urandom;
         #2;
         total++;
         if (data_addr_ok !== 1'b1) $display("FAIL full_fill%0d got %b exp 1", i, data_addr_ok);
         else pass_cnt++;
         tick();
      end
      inst_req = 1;
      #2;
      total++;
      if ({mem_req, data_addr_ok, inst_addr_ok} !== 3'b000)
         $display("FAIL full_block got %b%b%b exp 000", mem_req, data_addr_ok, inst_addr_ok);
      else pass_cnt++;
      tick();
      mem_data_ok = 1;
      #2;
      total++;
      if ({mem_req, data_addr_ok, data_data_ok} !== 3'b001)
         $display("FAIL full_pop_no_push got %b%b%b exp 001", mem_req, data_addr_ok, data_data_ok);
      else pass_cnt++;
      tick();
      mem_data_ok = 0;
      #2;
      total++;
      if ({mem_req, data_addr_ok, inst_addr_ok} !== 3'b110)
         $display("FAIL full_resume got %b%b%b exp 110", mem_req, data_addr_ok, inst_addr_ok);
      else pass_cnt++;
      tick();
      data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      for (int i = 0; i < 4; i++) begin
         #2;
         total++;
         if ({data_data_ok, inst_data_ok} !== 2'b10)
            $display("FAIL full_drain%0d got %b%b exp 10", i, data_data_ok, inst_data_ok);
         else pass_cnt++;
         tick();
      end
      idle_inputs();
   endtask

   task test_order;
      logic [2:0] exp_src;
      exp_src = 3'b101;
      mem_addr_ok = 1; data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_addr = $urandom;
      #2;
      total++;
      if ({data_addr_ok, mem_wr, mem_wstrb} !== 6'b110011)
         $display("FAIL order_acc_wr got %b %b %h exp 1 1 3", data_addr_ok, mem_wr, mem_wstrb);
      else pass_cnt++;
      tick();
      data_req = 0; inst_req = 1;
      #2;
      total++;
      if (inst_addr_ok !== 1'b1) $display("FAIL order_acc_inst got %b exp 1", inst_addr_ok);
      else pass_cnt++;
      tick();
      inst_req = 0; data_req = 1; data_wr = 0;
      #2;
      total++;
      if ({data_addr_ok, mem_wr} !== 2'b10) $display("FAIL order_acc_rd got %b%b exp 10", data_addr_ok, mem_wr);
      else pass_cnt++;
      tick();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      for (int i = 0; i < 3; i++) begin
         mem_rdata = $urandom;
         #2;
         total++;
         if ({data_data_ok, inst_data_ok, data_rdata, inst_rdata} !==
             {exp_src[2-i], !exp_src[2-i], mem_rdata, mem_rdata})
            $display("FAIL order_resp%0d got %b%b %h exp %b%b %h", i, data_data_ok, inst_data_ok,
                     data_rdata, exp_src[2-i], !exp_src[2-i], mem_rdata);
         else pass_cnt++;
         tick();
      end
      idle_inputs();
   endtask

   task test_stray;
      mem_data_ok = 1;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok} !== 2'b00)
         $display("FAIL stray_empty got %b%b exp 00", data_data_ok, inst_data_ok);
      else pass_cnt++;
      tick();
      mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
      tick();
      tick();
      data_req = 0; mem_addr_ok = 0; reset = 1;
      tick();
      reset = 0; mem_data_ok = 1;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok} !== 2'b00)
         $display("FAIL stray_after_reset got %b%b exp 00", data_data_ok, inst_data_ok);
      else pass_cnt++;
      tick();
      mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok} !== 2'b01)
         $display("FAIL stray_fresh_route got %b%b exp 01", data_data_ok, inst_data_ok);
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   task test_back_to_back;
      bit src[9];
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) src[i] = $urandom_range(0, 1);
         data_req = (i < 8) && src[i];
         inst_req = (i < 8) && !src[i];
         mem_addr_ok = (i < 8);
         mem_data_ok = (i > 0);
         mem_rdata = $urandom;
         #2;
         if (i < 8) begin
            total++;
            if ({data_addr_ok, inst_addr_ok} !== {src[i], !src[i]})
               $display("FAIL b2b_acc%0d got %b%b exp %b%b", i, data_addr_ok, inst_addr_ok, src[i], !src[i]);
            else pass_cnt++;
         end
         if (i > 0) begin
            total++;
            if ({data_data_ok, inst_data_ok} !== {src[i-1], !src[i-1]})
               $display("FAIL b2b_resp%0d got %b%b exp %b%b", i - 1, data_data_ok, inst_data_ok,
                        src[i-1], !src[i-1]);
            else pass_cnt++;
         end
         tick();
      end
      idle_inputs();
      mem_data_ok = 1;
      #2;
      total++;
      if ({data_data_ok, inst_data_ok} !== 2'b00)
         $display("FAIL b2b_counter_zero got %b%b exp 00", data_data_ok, inst_data_ok);
      else pass_cnt++;
      tick();
      idle_inputs();
   endtask

   task test_random;
      bit ip, dp;
      ip = 0; dp = 0;
      for (int c = 0; c < 600; c++) begin
         if (!ip) begin inst_req = ($urandom_range(0, 2) == 0); inst_addr = $urandom; ip = inst_req; end
         if (!dp) begin
            data_req = ($urandom_range(0, 2) == 0); data_wr = $urandom_range(0, 1);
            data_wstrb = $urandom; data_addr = $urandom; data_size = $urandom; data_wdata = $urandom;
            dp = data_req;
         end
         mem_addr_ok = $urandom_range(0, 1);
         mem_data_ok = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         reset = ($urandom_range(0, 79) == 0);
         #2;
         model_eval();
         total++;
         if ({mem_req, data_addr_ok, inst_addr_ok, data_data_ok, inst_data_ok} !==
             {e_req, e_daok, e_iaok, e_ddok, e_idok})
            $display("FAIL rand_ctrl cyc=%0d got %b exp %b", c,
                     {mem_req, data_addr_ok, inst_addr_ok, data_data_ok, inst_data_ok},
                     {e_req, e_daok, e_iaok, e_ddok, e_idok});
         else pass_cnt++;
         total++;
         if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata})
            $display("FAIL rand_rdata cyc=%0d got %h %h exp %h", c, inst_rdata, data_rdata, mem_rdata);
         else pass_cnt++;
         if (e_req) begin
            total++;
            if ({mem_wr, mem_wstrb, mem_addr, mem_size, mem_wdata} !== {e_wr, e_wstrb, e_addr, e_size, e_wdata})
               $display("FAIL rand_payload cyc=%0d got %b %h %h %0d %h exp %b %h %h %0d %h", c,
                        mem_wr, mem_wstrb, mem_addr, mem_size, mem_wdata, e_wr, e_wstrb, e_addr, e_size, e_wdata);
            else pass_cnt++;
         end
         if (e_daok) dp = 0;
         if (e_iaok) ip = 0;
         tick();
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      lk_v = 0; lk_d = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_priority();
      test_hold();
      test_full();
      test_order();
      test_stray();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
